// File: rtl/cmd_snd_if.sv
// cmd_snd_if: bundles the host request, UART transmitter and UART receiver
// signals of the command initiator.
//   master : the command initiator (cmd_snd) side
//   slave  : the environment side (host stimulus plus UART transceiver)
// Signals:
//   snd_cmd/cmd/data        host request (1-cycle strobe, opcode, payload)
//   tx_data/trmt/tx_done    byte-level UART transmitter handshake
//   rx_rdy/rx_data/clr_rx_rdy  UART receiver handshake
//   cmd_sent/resp/resp_rdy/busy/timeout  status back to the host
interface cmd_snd_if;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        busy;
  logic        timeout;

  modport master (
    input  snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
    output tx_data, trmt, clr_rx_rdy, cmd_sent, resp, resp_rdy, busy, timeout
  );

  modport slave (
    output snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
    input  tx_data, trmt, clr_rx_rdy, cmd_sent, resp, resp_rdy, busy, timeout
  );
endinterface

// File: rtl/cmd_snd.sv
// cmd_snd: host-side command initiator for the quadcopter command link.
// A request (8-bit opcode + 16-bit payload) is latched and sent as three
// bytes (cmd, data[15:8], data[7:0]) through a byte UART transmitter, then
// a single response byte is awaited from the UART receiver, with a timeout.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cmd_snd_if.master (request, UART tx/rx handshakes, status)
// Parameter:
//   TMO_W  response timeout counter width; timeout after 2^TMO_W-1 cycles
//          spent waiting for the response (TMO_W >= 2)
module cmd_snd #(
  parameter int TMO_W = 16
) (
  input logic       clk,
  input logic       rst_n,
  cmd_snd_if.master bus
);

  typedef enum logic [2:0] {IDLE, TX_CMD, TX_HI, TX_LO, WAIT_RESP} state_t;

  // The timeout is taken on the edge where the counter would step onto
  // all-ones, so it lands exactly 2^TMO_W-1 cycles after entering WAIT_RESP.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state;
  state_t           state_nxt;
  logic [23:0]      shadow;
  logic [TMO_W-1:0] tmo_cnt;
  logic             rx_fresh;
  logic             tmo_hit;

  // rx_rdy is a level that the receiver only drops after seeing our
  // registered clr_rx_rdy, so the cycle in which clr is already high still
  // shows the old byte; masking it prevents a double consume.
  assign rx_fresh = bus.rx_rdy & ~bus.clr_rx_rdy;
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: requests only start from IDLE, each byte advances on
  // its tx_done, and the wait ends on a response (priority) or a timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.snd_cmd)           state_nxt = TX_CMD;
      TX_CMD:    if (bus.tx_done)           state_nxt = TX_HI;
      TX_HI:     if (bus.tx_done)           state_nxt = TX_LO;
      TX_LO:     if (bus.tx_done)           state_nxt = WAIT_RESP;
      WAIT_RESP: if (rx_fresh || tmo_hit)   state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state: the byte on offer is selected
  // from the shadow copy, so it stays put until that byte's tx_done.
  always_comb begin
    bus.tx_data = 8'h00;
    case (state)
      TX_CMD:  bus.tx_data = shadow[23:16];
      TX_HI:   bus.tx_data = shadow[15:8];
      TX_LO:   bus.tx_data = shadow[7:0];
      default: bus.tx_data = 8'h00;
    endcase
    bus.busy = (state != IDLE);
  end

  // Registered strobes, request shadow, response capture and the timeout
  // counter. trmt fires on the edge that enters any transmit state, which
  // gives the one-cycle latency from snd_cmd and from each tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow         <= '0;
      tmo_cnt        <= '0;
      bus.trmt       <= 1'b0;
      bus.cmd_sent   <= 1'b0;
      bus.clr_rx_rdy <= 1'b0;
      bus.resp       <= 8'h00;
      bus.resp_rdy   <= 1'b0;
      bus.timeout    <= 1'b0;
    end else begin
      bus.trmt       <= (state_nxt != state) && (state_nxt != IDLE) &&
                        (state_nxt != WAIT_RESP);
      bus.cmd_sent   <= (state == TX_LO) && bus.tx_done;
      // Any fresh byte is consumed: it is either the response or a stray.
      bus.clr_rx_rdy <= rx_fresh;

      if (state == IDLE && bus.snd_cmd) begin
        shadow       <= {bus.cmd, bus.data};
        bus.resp_rdy <= 1'b0;
        bus.timeout  <= 1'b0;
      end

      if (state == TX_LO && bus.tx_done) tmo_cnt <= '0;
      else if (state == WAIT_RESP)       tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (state == WAIT_RESP) begin
        if (rx_fresh) begin
          bus.resp     <= bus.rx_data;
          bus.resp_rdy <= 1'b1;
        end else if (tmo_hit) begin
          bus.timeout  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/cmd_snd.md
Name: cmd_snd

Overview:
- Host-side command initiator: the remote end of the quadcopter command link.
- Takes one command request (8-bit opcode plus 16-bit data) and serializes it as three bytes into a byte-level UART transmitter.
- Then waits for the single response byte from the UART receiver: 8'hA5 positive ack, or the battery byte for REQ_BATT.
- Sits between the host/test stimulus and a UART transceiver; mirrors the flight-side command decoder.

Parameters:
TMO_W, 16, width of the response-timeout counter; timeout fires when the counter reaches all-ones (2^TMO_W-1 cycles in WAIT_RESP).

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
snd_cmd  input  1  single-cycle request to send cmd/data; honoured only in IDLE
cmd  input  8  opcode (01 REQ_BATT, 02 PTCH, 03 ROLL, 04 YAW, 05 THRST, 06 CAL, 07 EMER, 08 MTRS_OFF); not range-checked
data  input  16  command payload
tx_data  output  8  byte to UART transmitter
trmt  output  1  one-cycle pulse: start transmitting tx_data
tx_done  input  1  one-cycle pulse from transmitter: byte fully shifted out
rx_rdy  input  1  level from receiver: rx_data valid
rx_data  input  8  received byte
clr_rx_rdy  output  1  one-cycle pulse: consume received byte
cmd_sent  output  1  one-cycle pulse when third byte's tx_done seen
resp  output  8  captured response byte
resp_rdy  output  1  level: resp valid
busy  output  1  high in every state except IDLE
timeout  output  1  level: last command got no response

Behaviour:
- Reset values:
  - tx_data=0, trmt=0, clr_rx_rdy=0, cmd_sent=0, resp=0, resp_rdy=0, busy=0, timeout=0.
  - State=IDLE, timeout counter=0.
  - Reset mid-operation abandons the transfer immediately; no further trmt.
- States: IDLE, TX_CMD, TX_HI, TX_LO, WAIT_RESP.
- IDLE:
  - On snd_cmd: latch {cmd,data} into a 24-bit shadow register, clear resp_rdy and timeout.
  - Go to TX_CMD and assert trmt with tx_data=cmd on the next cycle (1-cycle latency from snd_cmd to first trmt).
- Byte order: cmd, data[15:8], data[7:0].
  - Payload bytes are sent from the shadow register, so input changes after snd_cmd have no effect.
- TX_CMD / TX_HI / TX_LO:
  - trmt pulses exactly one cycle on state entry.
  - tx_data is held stable from that trmt until the matching tx_done.
  - On tx_done, advance; the next byte's trmt is asserted the cycle after tx_done.
- TX_LO + tx_done: pulse cmd_sent, clear timeout counter, go to WAIT_RESP.
- WAIT_RESP:
  - The counter increments every cycle.
  - If rx_rdy: resp<=rx_data, resp_rdy<=1, pulse clr_rx_rdy, go to IDLE.
  - Else if the counter is all-ones: timeout<=1, go to IDLE; resp and resp_rdy unchanged (resp_rdy already 0).
  - If rx_rdy and counter-full occur in the same cycle, rx_rdy wins: the response is captured and there is no timeout.
- Stray rx_rdy outside WAIT_RESP: pulse clr_rx_rdy, discard the byte; resp/resp_rdy unaffected.
- snd_cmd while busy=1 is ignored entirely: no latch, no flag changes.
- tx_done outside TX states is ignored.
- No protocol interpretation of response content: any byte is accepted as the response.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to trmt.

Test Plan:
- Happy path: snd_cmd with cmd=02, data=16'h1234; tx_done returned 10 cycles after each trmt.
  -> tx_data sequence 02, 12, 34, each with a single trmt pulse.
  -> cmd_sent pulses once after the third tx_done.
  -> rx_data=A5 with rx_rdy -> resp=A5, resp_rdy=1, clr_rx_rdy pulsed 1 cycle, busy=0.
- Battery: cmd=01, data=0; reply rx_data=8'hC3.
  -> bytes 01, 00, 00 sent; resp=C3, resp_rdy=1.
  -> Next snd_cmd clears resp_rdy the following cycle.
- Timeout: TMO_W=4, no rx_rdy after cmd_sent.
  -> timeout=1 and busy=0 exactly 15 cycles after entering WAIT_RESP; resp_rdy stays 0.
  -> Coincident rx_rdy on the full cycle instead yields a response capture and timeout=0.
- Busy rejection: second snd_cmd with cmd=05, data=16'h0FF pulsed during TX_HI.
  -> Transmitted bytes remain those of the first command; no extra trmt.
  -> cmd/data changed after the first snd_cmd do not alter the transmitted bytes.
- Reset mid-transfer: assert rst_n=0 while in TX_HI.
  -> All outputs return to reset values asynchronously.
  -> After release, no trmt until a new snd_cmd; a fresh command transmits correctly.
- Stray receive: rx_rdy with rx_data=5A while IDLE.
  -> clr_rx_rdy pulses once; resp and resp_rdy unchanged.
